// File: rtl/ex_wb_stage.sv
// EX/WB pipeline register with an 8-entry register file and a retired-write counter.
// Define WB_BYPASS_EN to forward the committing result onto matching read ports in the same cycle.
module ex_wb_stage #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic              ex_reg_write,
    input  logic [2:0]        ex_rd,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              stall,
    input  logic              flush,
    input  logic [2:0]        rd_addr_a,
    input  logic [2:0]        rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              ex_wb_reg_write,
    output logic [2:0]        ex_wb_rd,
    output logic [DATA_W-1:0] ex_wb_result,
    output logic [15:0]       retire_count
);

    logic              commit;
    logic [DATA_W-1:0] rf [8];

    // The held EX/WB content commits whenever the pipe advances; a same-cycle flush
    // only affects the younger instruction being captured, so it does not gate this.
    assign commit = ex_wb_reg_write & ~stall;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values, independent of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_wb_reg_write <= 1'b0;
            ex_wb_rd        <= '0;
            ex_wb_result    <= '0;
        end else if (flush) begin
            ex_wb_reg_write <= 1'b0;
            ex_wb_rd        <= '0;
            ex_wb_result    <= '0;
        end else if (!stall) begin
            ex_wb_reg_write <= ex_valid & ex_reg_write;
            ex_wb_rd        <= ex_rd;
            ex_wb_result    <= ex_result;
        end
    end

    // NOTE: the register file is cleared by reset, so it is built from flops rather
    // than an inferred RAM macro; this keeps reads deterministic straight after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                rf[i] <= '0;
            end
        end else if (commit) begin
            rf[ex_wb_rd] <= ex_wb_result;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retire_count <= '0;
        end else if (commit) begin
            retire_count <= retire_count + 16'd1;
        end
    end

    // NOTE: each combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        rd_data_a = rf[rd_addr_a];
        rd_data_b = rf[rd_addr_b];
`ifdef WB_BYPASS_EN
        if (commit && (rd_addr_a == ex_wb_rd)) begin
            rd_data_a = ex_wb_result;
        end
        if (commit && (rd_addr_b == ex_wb_rd)) begin
            rd_data_b = ex_wb_result;
        end
`else
`endif
    end

endmodule

// File: tb/tb_ex_wb_stage.sv
// Randomized scoreboard bench for ex_wb_stage: stimulus pushes the expected visible
// state of each cycle, a monitor pops and compares it just before the next rising edge.
module tb_ex_wb_stage;

    localparam int DATA_W = 8;
`ifdef WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              ex_valid = 1'b0;
    logic              ex_reg_write = 1'b0;
    logic [2:0]        ex_rd = '0;
    logic [DATA_W-1:0] ex_result = '0;
    logic              stall = 1'b0;
    logic              flush = 1'b0;
    logic [2:0]        rd_addr_a = '0;
    logic [2:0]        rd_addr_b = '0;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic              ex_wb_reg_write;
    logic [2:0]        ex_wb_rd;
    logic [DATA_W-1:0] ex_wb_result;
    logic [15:0]       retire_count;

    ex_wb_stage #(.DATA_W(DATA_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .ex_valid        (ex_valid),
        .ex_reg_write    (ex_reg_write),
        .ex_rd           (ex_rd),
        .ex_result       (ex_result),
        .stall           (stall),
        .flush           (flush),
        .rd_addr_a       (rd_addr_a),
        .rd_addr_b       (rd_addr_b),
        .rd_data_a       (rd_data_a),
        .rd_data_b       (rd_data_b),
        .ex_wb_reg_write (ex_wb_reg_write),
        .ex_wb_rd        (ex_wb_rd),
        .ex_wb_result    (ex_wb_result),
        .retire_count    (retire_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                cyc;
        logic              w;
        logic [2:0]        rd;
        logic [DATA_W-1:0] res;
        logic [15:0]       cnt;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc_no = 0;
    bit   stim_done = 1'b0;
    bit   mon_done = 1'b0;

    // Reference model: architectural state of the stage
    logic              m_w;
    logic [2:0]        m_rd;
    logic [DATA_W-1:0] m_res;
    logic [15:0]       m_cnt;
    logic [DATA_W-1:0] m_rf [8];

    task automatic check(input string name, input int cyc, input logic [15:0] act,
                         input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_clear();
        m_w   = 1'b0;
        m_rd  = '0;
        m_res = '0;
        m_cnt = '0;
        for (int i = 0; i < 8; i++) m_rf[i] = '0;
    endtask

    function automatic logic [DATA_W-1:0] model_read(input logic [2:0] addr, input bit st);
        if (BYPASS && m_w && !st && addr == m_rd) return m_res;
        return m_rf[addr];
    endfunction

    // One cycle: drive inputs at the falling edge, publish the expectation, advance the model.
    task automatic cyc(input bit v, input bit rw, input logic [2:0] rd,
                       input logic [DATA_W-1:0] res, input bit st, input bit fl,
                       input logic [2:0] ra, input logic [2:0] rb,
                       input bit rst, input bit late_rst, input bit frc);
        exp_t e;
        @(negedge clk);
        cyc_no++;
        reset        = rst;
        ex_valid     = v;
        ex_reg_write = rw;
        ex_rd        = rd;
        ex_result    = res;
        stall        = st;
        flush        = fl;
        rd_addr_a    = ra;
        rd_addr_b    = rb;
        if (rst || late_rst) model_clear();
        if (frc) begin
            force dut.retire_count = 16'hFFFF;
            m_cnt = 16'hFFFF;
        end
        e.cyc = cyc_no;
        e.w   = m_w;
        e.rd  = m_rd;
        e.res = m_res;
        e.cnt = m_cnt;
        e.a   = model_read(ra, st);
        e.b   = model_read(rb, st);
        q.push_back(e);
        if (!(rst || late_rst)) begin
            if (m_w && !st) begin
                m_rf[m_rd] = m_res;
                m_cnt      = m_cnt + 16'd1;
            end
            if (fl) begin
                m_w = 1'b0; m_rd = '0; m_res = '0;
            end else if (!st) begin
                m_w = v && rw; m_rd = rd; m_res = res;
            end
        end
        if (late_rst) begin
            #1 reset = 1'b1;
        end
        if (frc) begin
            #4 release dut.retire_count;
        end
    endtask

    // Monitor: compares the DUT against each published expectation
    initial begin
        exp_t e;
        while (!stim_done || q.size() > 0) begin
            @(negedge clk);
            #3;
            if (q.size() == 0) begin
                if (!stim_done) check("scoreboard_underflow", cyc_no, 16'd1, 16'd0);
            end else begin
                e = q.pop_front();
                check("ex_wb_reg_write", e.cyc, {15'd0, ex_wb_reg_write}, {15'd0, e.w});
                check("ex_wb_rd", e.cyc, {13'd0, ex_wb_rd}, {13'd0, e.rd});
                check("ex_wb_result", e.cyc, {8'd0, ex_wb_result}, {8'd0, e.res});
                check("retire_count", e.cyc, retire_count, e.cnt);
                check("rd_data_a", e.cyc, {8'd0, rd_data_a}, {8'd0, e.a});
                check("rd_data_b", e.cyc, {8'd0, rd_data_b}, {8'd0, e.b});
            end
        end
        mon_done = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        model_clear();
        // Reset state, then capture and read of r3
        cyc(0, 0, 0, 8'h00, 0, 0, 3'd3, 3'd0, 1, 0, 0);
        cyc(0, 0, 0, 8'h00, 0, 0, 3'd3, 3'd7, 1, 0, 0);
        cyc(1, 1, 3'd3, 8'h5A, 0, 0, 3'd3, 3'd0, 0, 0, 0);
        cyc(0, 0, 3'd0, 8'h00, 0, 0, 3'd3, 3'd3, 0, 0, 0);
        cyc(0, 0, 3'd0, 8'h00, 0, 0, 3'd3, 3'd1, 0, 0, 0);
        // Stall held for three cycles then released
        cyc(1, 1, 3'd2, 8'h11, 0, 0, 3'd2, 3'd3, 0, 0, 0);
        cyc(1, 1, 3'd6, 8'h66, 1, 0, 3'd2, 3'd6, 0, 0, 0);
        cyc(1, 1, 3'd6, 8'h66, 1, 0, 3'd2, 3'd2, 0, 0, 0);
        cyc(1, 1, 3'd6, 8'h66, 1, 0, 3'd2, 3'd6, 0, 0, 0);
        cyc(0, 0, 3'd0, 8'h00, 0, 0, 3'd2, 3'd6, 0, 0, 0);
        cyc(0, 0, 3'd0, 8'h00, 0, 0, 3'd2, 3'd6, 0, 0, 0);
        // Flush commits the older entry but bubbles the younger one
        cyc(1, 1, 3'd4, 8'h22, 0, 0, 3'd4, 3'd5, 0, 0, 0);
        cyc(1, 1, 3'd5, 8'h33, 0, 1, 3'd4, 3'd5, 0, 0, 0);
        cyc(0, 0, 3'd0, 8'h00, 0, 0, 3'd4, 3'd5, 0, 0, 0);
        // Stall and flush together: bubble, no commit
        cyc(1, 1, 3'd6, 8'h44, 0, 0, 3'd6, 3'd0, 0, 0, 0);
        cyc(1, 1, 3'd1, 8'h55, 1, 1, 3'd6, 3'd1, 0, 0, 0);
        cyc(0, 0, 3'd0, 8'h00, 0, 0, 3'd6, 3'd1, 0, 0, 0);
        // Invalid instruction never writes
        cyc(0, 1, 3'd1, 8'h77, 0, 0, 3'd1, 3'd0, 0, 0, 0);
        cyc(0, 0, 3'd0, 8'h00, 0, 0, 3'd1, 3'd1, 0, 0, 0);
        cyc(0, 0, 3'd0, 8'h00, 0, 0, 3'd1, 3'd0, 0, 0, 0);
        // Counter wrap from 0xFFFF
        cyc(1, 1, 3'd0, 8'h99, 0, 0, 3'd0, 3'd1, 0, 0, 0);
        cyc(0, 0, 3'd0, 8'h00, 0, 0, 3'd0, 3'd1, 0, 0, 1);
        cyc(0, 0, 3'd0, 8'h00, 0, 0, 3'd0, 3'd1, 0, 0, 0);
        // Asynchronous reset between edges with a pending write to r7
        cyc(1, 1, 3'd7, 8'hEE, 0, 0, 3'd7, 3'd3, 0, 0, 0);
        cyc(0, 0, 3'd0, 8'h00, 0, 0, 3'd7, 3'd3, 0, 1, 0);
        cyc(0, 0, 3'd0, 8'h00, 0, 0, 3'd0, 3'd1, 1, 0, 0);
        cyc(0, 0, 3'd0, 8'h00, 0, 0, 3'd2, 3'd3, 1, 0, 0);
        cyc(0, 0, 3'd0, 8'h00, 0, 0, 3'd4, 3'd5, 1, 0, 0);
        cyc(0, 0, 3'd0, 8'h00, 0, 0, 3'd6, 3'd7, 1, 0, 0);
        cyc(0, 0, 3'd0, 8'h00, 0, 0, 3'd7, 3'd7, 0, 0, 0);
        cyc(0, 0, 3'd0, 8'h00, 0, 0, 3'd7, 3'd4, 0, 0, 0);
        // Randomized traffic; read port A often targets the pending destination
        for (int i = 0; i < 400; i++) begin
            logic [2:0] ra;
            logic [2:0] rb;
            bit         late;
            ra   = ($urandom_range(0, 1) == 0) ? m_rd : 3'($urandom_range(0, 7));
            rb   = 3'($urandom_range(0, 7));
            late = ($urandom_range(0, 99) == 0);
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
                $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                ra, rb, 0, late, 0);
            if (late) begin
                cyc(0, 0, 3'd0, 8'h00, 0, 0, 3'd0, 3'd7, 1, 0, 0);
            end
        end
        stim_done = 1'b1;
        fork
            wait (mon_done);
            repeat (20) @(posedge clk);
        join_any
        disable fork;
        if (!mon_done) check("monitor_drain", cyc_no, 16'd0, 16'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
